apb5_parity_regbank: RTL and testbench

// - APB5 completer: bank of NUM_REGS read/write registers, byte-strobed writes, programmable wait states.
// - Per-byte odd-parity checking on PADDR/PWDATA/PSTRB and parity generation on PRDATA.
// - Error reporting via PSLVERR and a saturating error counter.
// - Endpoint for the Interrupt env APB master agent; register contents exported to downstream logic.

---
 rtl/apb5_parity_regbank_pkg.sv | 20 ++
 rtl/apb5_parity_regbank_if.sv | 31 +++
 rtl/apb5_parity_regbank_parity.sv | 19 +
 rtl/apb5_parity_regbank.sv | 183 ++++++++++++++++++
 tb/tb_apb5_parity_regbank.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb5_parity_regbank_pkg.sv
// Shared types and helpers for the APB5 parity register bank.
package apb5_regbank_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int bytes_of(input int width);
    return width / BYTE_W;
  endfunction

  // Odd parity: the byte plus the returned bit hold an odd number of ones.
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/apb5_parity_regbank_if.sv
// APB5 bus bundle with parity check signals; master drives requests, slave responds.
interface apb5_parity_regbank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [ADDR_WIDTH/8-1:0] PADDRCHK;
  logic [DATA_WIDTH/8-1:0] PWDATACHK;
  logic                    PSTRBCHK;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic [DATA_WIDTH/8-1:0] PRDATACHK;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PADDRCHK, PWDATACHK, PSTRBCHK,
    input  PREADY, PSLVERR, PRDATA, PRDATACHK
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PADDRCHK, PWDATACHK, PSTRBCHK,
    output PREADY, PSLVERR, PRDATA, PRDATACHK
  );
endinterface

// File: rtl/apb5_parity_regbank_parity.sv
// apb5_byte_parity: one odd-parity bit per byte of an N-byte vector.
// Compiled only when APB5_PARITY_CHECK_EN is defined.
`ifdef APB5_PARITY_CHECK_EN
module apb5_byte_parity
  import apb5_regbank_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic [NBYTES*8-1:0] data_i,
  output logic [NBYTES-1:0]   par_o
);
  always_comb begin
    par_o = '0;
    for (int b = 0; b < NBYTES; b++) begin
      par_o[b] = odd_par(data_i[b*8 +: 8]);
    end
  end
endmodule
`endif

// File: rtl/apb5_parity_regbank.sv
// APB5 completer: NUM_REGS byte-strobed registers, programmable wait states, error counter.
// Parity checking/generation is present only when APB5_PARITY_CHECK_EN is defined.
module apb5_parity_regbank
  import apb5_regbank_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  apb5_parity_regbank_if.slave           apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [7:0]                     err_cnt_o,
  output logic                           par_err_o
);

  localparam int BYTES  = bytes_of(DATA_WIDTH);
  localparam int ABYTES = bytes_of(ADDR_WIDTH);
  localparam int LSB    = $clog2(BYTES);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] NREGS_A    = ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0]            WS         = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pslverr_q, par_err_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [BYTES-1:0]      prdatachk_q;
  logic [7:0]            err_cnt_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Request captured on the setup cycle; only meaningful while in ACCESS.
  logic                  wr_q, err_q, perr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      strb_q;

  logic                  setup, capture, ld_resp, ld_rdata, commit;
  logic [ADDR_WIDTH-1:0] off, idx_full;
  logic [IDX_W-1:0]      idx_now, resp_idx;
  logic                  dec_err, par_err_now, err_now;
  logic                  resp_err, resp_perr, resp_wr;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic [BYTES-1:0]      prdchk_nxt;

  assign setup = apb.PSEL && !apb.PENABLE;

  always_comb begin
    off      = apb.PADDR - BASE_ADDR;
    idx_full = off >> LSB;
    idx_now  = idx_full[IDX_W-1:0];
    dec_err  = (apb.PADDR < BASE_ADDR) || ((off & ALIGN_MASK) != '0) || (idx_full >= NREGS_A);
  end

`ifdef APB5_PARITY_CHECK_EN
  logic [ABYTES-1:0] paddr_par;
  logic [BYTES-1:0]  pwdata_par;
  logic [BYTES-1:0]  prdata_par;

  apb5_byte_parity #(.NBYTES(ABYTES)) u_paddr_par  (.data_i(apb.PADDR),  .par_o(paddr_par));
  apb5_byte_parity #(.NBYTES(BYTES))  u_pwdata_par (.data_i(apb.PWDATA), .par_o(pwdata_par));
  apb5_byte_parity #(.NBYTES(BYTES))  u_prdata_par (.data_i(rdata_nxt),  .par_o(prdata_par));

  assign par_err_now = (paddr_par != apb.PADDRCHK)
                    || ((~^apb.PSTRB) != apb.PSTRBCHK)
                    || (apb.PWRITE && (pwdata_par != apb.PWDATACHK));
  assign prdchk_nxt  = prdata_par;
`else
  logic unused_chk;
  assign unused_chk  = ^{apb.PADDRCHK, apb.PWDATACHK, apb.PSTRBCHK};
  assign par_err_now = 1'b0;
  assign prdchk_nxt  = '0;
`endif

  assign err_now = dec_err || par_err_now;

  // With zero wait states the response is built straight from the live setup cycle.
  always_comb begin
    resp_err  = (state_q == IDLE) ? err_now     : err_q;
    resp_perr = (state_q == IDLE) ? par_err_now : perr_q;
    resp_wr   = (state_q == IDLE) ? apb.PWRITE  : wr_q;
    resp_idx  = (state_q == IDLE) ? idx_now     : idx_q;
    rdata_nxt = resp_err ? '0 : regs_q[resp_idx];
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS:  if (!apb.PSEL || pready_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    capture = 1'b0;
    ld_resp = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          capture = 1'b1;
          cnt_d   = WS;
          ld_resp = (WS == 4'd0);
        end
      end
      ACCESS: begin
        if (apb.PSEL) begin
          if (pready_q) begin
            commit = 1'b1;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            ld_resp = (cnt_q == 4'd1);
          end
        end
      end
      default: ;
    endcase
    ld_rdata = ld_resp && (resp_err || !resp_wr);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      par_err_q   <= 1'b0;
      prdata_q    <= '0;
      prdatachk_q <= '0;
      err_cnt_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pready_q  <= ld_resp;
      pslverr_q <= ld_resp && resp_err;
      par_err_q <= ld_resp && resp_perr;
      if (ld_rdata) begin
        prdata_q    <= rdata_nxt;
        prdatachk_q <= prdchk_nxt;
      end
      if (commit && err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (commit && wr_q && !err_q) begin
        for (int b = 0; b < BYTES; b++) begin
          if (strb_q[b]) regs_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (capture) begin
      wr_q    <= apb.PWRITE;
      err_q   <= err_now;
      perr_q  <= par_err_now;
      idx_q   <= idx_now;
      wdata_q <= apb.PWDATA;
      strb_q  <= apb.PSTRB;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign apb.PREADY    = pready_q;
  assign apb.PSLVERR   = pslverr_q;
  assign apb.PRDATA    = prdata_q;
  assign apb.PRDATACHK = prdatachk_q;
  assign err_cnt_o     = err_cnt_q;
  assign par_err_o     = par_err_q;

endmodule

// File: tb/tb_apb5_parity_regbank.sv
// Bench for apb5_parity_regbank: two instances (0 and 3 wait states, bases 0x0 and 0x100).
module tb_apb5_parity_regbank;

`ifdef APB5_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int WS_A = 0;
  localparam int WS_B = 3;
  localparam logic [31:0] BASE_A = 32'h0;
  localparam logic [31:0] BASE_B = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        dsel = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pstrbchk = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0, paddrchk = '0, pwdatachk = '0;

  apb5_parity_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  apb5_parity_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  assign ifa.PSEL = psel & ~dsel;
  assign ifb.PSEL = psel & dsel;
  assign ifa.PENABLE = penable;   assign ifb.PENABLE = penable;
  assign ifa.PWRITE = pwrite;     assign ifb.PWRITE = pwrite;
  assign ifa.PADDR = paddr;       assign ifb.PADDR = paddr;
  assign ifa.PWDATA = pwdata;     assign ifb.PWDATA = pwdata;
  assign ifa.PSTRB = pstrb;       assign ifb.PSTRB = pstrb;
  assign ifa.PADDRCHK = paddrchk; assign ifb.PADDRCHK = paddrchk;
  assign ifa.PWDATACHK = pwdatachk; assign ifb.PWDATACHK = pwdatachk;
  assign ifa.PSTRBCHK = pstrbchk; assign ifb.PSTRBCHK = pstrbchk;

  logic [511:0] regs_a, regs_b;
  logic [7:0]   ecnt_a, ecnt_b;
  logic         perr_a, perr_b;

  apb5_parity_regbank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
                        .WAIT_STATES(WS_A), .BASE_ADDR(BASE_A)) u_a (
    .PCLK(clk), .PRESET(rst), .apb(ifa), .regs_o(regs_a), .err_cnt_o(ecnt_a), .par_err_o(perr_a));
  apb5_parity_regbank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
                        .WAIT_STATES(WS_B), .BASE_ADDR(BASE_B)) u_b (
    .PCLK(clk), .PRESET(rst), .apb(ifb), .regs_o(regs_b), .err_cnt_o(ecnt_b), .par_err_o(perr_b));

  wire         pready  = dsel ? ifb.PREADY    : ifa.PREADY;
  wire         pslverr = dsel ? ifb.PSLVERR   : ifa.PSLVERR;
  wire [31:0]  prdata  = dsel ? ifb.PRDATA    : ifa.PRDATA;
  wire [3:0]   prdchk  = dsel ? ifb.PRDATACHK : ifa.PRDATACHK;
  wire         perr    = dsel ? perr_b        : perr_a;
  wire [7:0]   ecnt    = dsel ? ecnt_b        : ecnt_a;
  wire [511:0] regs    = dsel ? regs_b        : regs_a;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: register contents and error counter per instance.
  logic [31:0] mregs [2][16];
  int          merr  [2];

  task automatic check(input string tag, input string what, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", tag, what, act, exp);
    end
  endtask

  function automatic logic [3:0] par4(input logic [31:0] v);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = ~^v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [511:0] mflat(input int d);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = mregs[d][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      merr[d] = 0;
      for (int i = 0; i < 16; i++) mregs[d][i] = '0;
    end
  endtask

  // bad_a: 0 none, 1 corrupt PADDRCHK[0], 2 corrupt PSTRBCHK. bad_d corrupts PWDATACHK[0].
  task automatic model(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int bad_a, input bit bad_d,
                       output bit e, output logic [31:0] rd, output bit pe);
    logic [31:0] base;
    logic [31:0] idx;
    base = (d == 1) ? BASE_B : BASE_A;
    idx  = (addr - base) / 4;
    pe   = PAR_EN && ((bad_a != 0) || (wr && bad_d));
    e    = (addr < base) || (addr % 4 != 0) || (idx >= 16) || pe;
    rd   = '0;
    if (e) begin
      if (merr[d] < 255) merr[d]++;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mregs[d][idx][b*8 +: 8] = data[b*8 +: 8];
    end else begin
      rd = mregs[d][idx];
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 right after the PREADY cycle, bus idle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int bad_a, input bit bad_d,
                      output logic [31:0] rd, output logic [3:0] rchk, output logic se,
                      output logic pe, output int lat);
    bit done = 0;
    dsel = d[0]; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb;
    paddrchk  = par4(addr) ^ ((bad_a == 1) ? 4'b0001 : 4'b0000);
    pwdatachk = par4(data) ^ {3'b000, bad_d};
    pstrbchk  = (~^strb) ^ (bad_a == 2);
    rd = 'x; rchk = 'x; se = 'x; pe = 'x; lat = 0;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (pready === 1'b1) begin
        rd = prdata; rchk = prdchk; se = pslverr; pe = perr; done = 1;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!done) check("xfer", "pready timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_xfer(input string tag, input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input int bad_a,
                         input bit bad_d, output logic se, output logic [31:0] rd);
    bit e, pe;
    logic [31:0] erd;
    logic [3:0] rchk, echk;
    logic pa;
    int lat;
    model(d, wr, addr, data, strb, bad_a, bad_d, e, erd, pe);
    xfer(d, wr, addr, data, strb, bad_a, bad_d, rd, rchk, se, pa, lat);
    echk = PAR_EN ? par4(erd) : 4'b0000;
    check(tag, "latency", lat, (d == 1) ? WS_B + 1 : WS_A + 1);
    check(tag, "pslverr", se, e);
    check(tag, "par_err", pa, pe);
    if (!wr || e) begin
      check(tag, "prdata", rd, erd);
      check(tag, "prdatachk", rchk, echk);
    end
    check(tag, "regs", regs, mflat(d));
    check(tag, "err_cnt", ecnt, merr[d]);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          bad_a;
    bit          bad_d;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic se;
    logic [31:0] rd, held;
    int d, sel;
    logic [31:0] addr;

    tbl[0]  = '{0, 32'h00, 32'h0,        4'hF,    0, 0, 0,      32'h0};
    tbl[1]  = '{1, 32'h08, 32'hDEADBEEF, 4'b0101, 0, 0, 0,      32'h0};
    tbl[2]  = '{0, 32'h08, 32'h0,        4'hF,    0, 0, 0,      32'h00AD00EF};
    tbl[3]  = '{0, 32'h40, 32'h0,        4'hF,    0, 0, 1,      32'h0};
    tbl[4]  = '{1, 32'h02, 32'hFFFFFFFF, 4'hF,    0, 0, 1,      32'h0};
    tbl[5]  = '{0, 32'h00, 32'h0,        4'hF,    0, 0, 0,      32'h0};
    tbl[6]  = '{1, 32'h04, 32'h12345678, 4'hF,    0, 1, PAR_EN, 32'h0};
    tbl[7]  = '{0, 32'h04, 32'h0,        4'hF,    0, 0, 0,      PAR_EN ? 32'h0 : 32'h12345678};
    tbl[8]  = '{1, 32'h08, 32'hFFFFFFFF, 4'h0,    0, 0, 0,      32'h0};
    tbl[9]  = '{0, 32'h08, 32'h0,        4'hF,    0, 0, 0,      32'h00AD00EF};
    tbl[10] = '{1, 32'h0C, 32'hCAFEF00D, 4'b1010, 0, 0, 0,      32'h0};
    tbl[11] = '{0, 32'h0C, 32'h0,        4'hF,    1, 0, PAR_EN, PAR_EN ? 32'h0 : 32'hCA00F000};
    tbl[12] = '{0, 32'h0C, 32'h0,        4'hF,    0, 1, 0,      32'hCA00F000};
    tbl[13] = '{1, 32'h3C, 32'h01020304, 4'hF,    2, 0, PAR_EN, 32'h0};
    tbl[14] = '{0, 32'h3C, 32'h0,        4'hF,    0, 0, 0,      PAR_EN ? 32'h0 : 32'h01020304};
    tbl[15] = '{0, 32'h3E, 32'h0,        4'hF,    0, 0, 1,      32'h0};

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", "pready_a", ifa.PREADY, 1'b0);
    check("reset", "pslverr_a", ifa.PSLVERR, 1'b0);
    check("reset", "prdata_a", ifa.PRDATA, 32'h0);
    check("reset", "prdatachk_a", ifa.PRDATACHK, 4'h0);
    check("reset", "err_cnt_a", ecnt_a, 8'h0);
    check("reset", "par_err_a", perr_a, 1'b0);
    check("reset", "regs_a", regs_a, '0);
    check("reset", "pready_b", ifb.PREADY, 1'b0);
    check("reset", "regs_b", regs_b, '0);
    @(posedge clk); #1;

    // Table vectors on the zero-wait instance, issued back-to-back.
    for (int i = 0; i < 16; i++) begin
      do_xfer("tbl", 0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb,
              tbl[i].bad_a, tbl[i].bad_d, se, rd);
      check("tbl", "vec_slverr", se, tbl[i].exp_err);
      if (!tbl[i].wr) check("tbl", "vec_rdata", rd, tbl[i].exp_rd);
    end

    // Read data holds after the PREADY cycle.
    do_xfer("hold", 0, 1'b0, 32'h08, 32'h0, 4'hF, 0, 0, se, held);
    repeat (2) @(negedge clk);
    check("hold", "prdata_idle", ifa.PRDATA, held);
    check("hold", "pready_idle", ifa.PREADY, 1'b0);
    @(posedge clk); #1;

    // PENABLE without a setup cycle is ignored.
    dsel = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("noset", "pready", ifa.PREADY, 1'b0);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("noset", "regs", regs_a, mflat(0));

    // Three wait states, base 0x100.
    do_xfer("ws", 1, 1'b1, 32'h104, 32'h11223344, 4'hF, 0, 0, se, rd);
    do_xfer("ws", 1, 1'b0, 32'h104, 32'h0, 4'hF, 0, 0, se, rd);
    do_xfer("ws", 1, 1'b0, 32'h0FC, 32'h0, 4'hF, 0, 0, se, rd);
    check("ws", "below_base_err", se, 1'b1);

    // Abort: PSEL dropped in the second access cycle.
    dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h108;
    pwdata = 32'h55667788; pstrb = 4'hF;
    paddrchk = par4(paddr); pwdatachk = par4(pwdata); pstrbchk = ~^pstrb;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort", "pready_acc1", ifb.PREADY, 1'b0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort", "pready_after", ifb.PREADY, 1'b0);
    end
    check("abort", "regs", regs_b, mflat(1));
    check("abort", "err_cnt", ecnt_b, merr[1]);
    @(posedge clk); #1;
    do_xfer("abort", 1, 1'b0, 32'h108, 32'h0, 4'hF, 0, 0, se, rd);
    do_xfer("abort", 1, 1'b1, 32'h108, 32'hA5A5A5A5, 4'b0011, 0, 0, se, rd);

    // Randomized traffic on both instances.
    for (int i = 0; i < 200; i++) begin
      d = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = (d ? BASE_B : BASE_A) + 4 * $urandom_range(0, 15);
      else if (sel == 7) addr = (d ? BASE_B : BASE_A) + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (sel == 8) addr = (d ? BASE_B : BASE_A) + 64 + 4 * $urandom_range(0, 15);
      else               addr = 4 * $urandom_range(0, 80);
      do_xfer("rand", d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0,
              ($urandom_range(0, 7) == 0), se, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Error counter saturation.
    for (int i = 0; i < 260; i++) do_xfer("sat", 0, 1'b0, 32'h80, 32'h0, 4'hF, 0, 0, se, rd);
    check("sat", "err_cnt_255", ecnt_a, 8'd255);

    // Reset in the middle of a transfer.
    dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h110;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    paddrchk = par4(paddr); pwdatachk = par4(pwdata); pstrbchk = ~^pstrb;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst", "pready", ifb.PREADY, 1'b0);
    check("midrst", "pslverr", ifb.PSLVERR, 1'b0);
    check("midrst", "prdata", ifb.PRDATA, 32'h0);
    check("midrst", "prdatachk", ifb.PRDATACHK, 4'h0);
    check("midrst", "regs_b", regs_b, '0);
    check("midrst", "regs_a", regs_a, '0);
    check("midrst", "err_cnt_a", ecnt_a, 8'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_xfer("post", 1, 1'b1, 32'h110, 32'h0BADF00D, 4'hF, 0, 0, se, rd);
    do_xfer("post", 1, 1'b0, 32'h110, 32'h0, 4'hF, 0, 0, se, rd);
    check("post", "rdata", rd, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
